// File: rtl/tiny_program_sequencer_pkg.sv
// Shared TinyCPU definitions: instruction field widths and the sequencer state set.
package tinycpu_pkg;

  localparam int OPC_W  = 4;
  localparam int DAT_W  = 8;
  localparam int INSN_W = OPC_W + DAT_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/tiny_program_sequencer_ram.sv
// Program store: DEPTH x INSN_W words, synchronous write, asynchronous read.
module program_ram
  import tinycpu_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [INSN_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [INSN_W-1:0] rd_data_o
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [INSN_W-1:0] mem_q [DEPTH];
  logic              wr_in_range;

  // Addresses past the end of the array are dropped when DEPTH < 2**ADDR_W.
  assign wr_in_range = ({1'b0, wr_addr_i} < DEPTH_L);

  always_ff @(posedge clk_i) begin
    if (we_i && wr_in_range) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/tiny_program_sequencer.sv
// Instruction issuer for the TinyCPU In port: run or single-step through a loaded program.
// Optional SEQ_LOOP_EN adds a Loop input that wraps the program instead of finishing.
//
// state | meaning
// IDLE  | waiting for Start, RAM writable
// RUN   | one word issued per clock
// STEP  | one word issued per Step pulse
// DONE  | program finished, RAM writable, Start relaunches
module tiny_program_sequencer
  import tinycpu_pkg::*;
#(
  parameter int                DEPTH     = 16,
  parameter int                ADDR_W    = 4,
  parameter logic [INSN_W-1:0] IDLE_WORD = 12'h000
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Wr_En,
  input  logic [ADDR_W-1:0] Wr_Addr,
  input  logic [INSN_W-1:0] Wr_Data,
  input  logic [ADDR_W:0]   Prog_Len,
  input  logic              Start,
  input  logic              Step_Mode,
  input  logic              Step,
  input  logic              Halt,
`ifdef SEQ_LOOP_EN
  input  logic              Loop,
`endif
  output logic [INSN_W-1:0] Out_Word,
  output logic              Out_Valid,
  output logic [ADDR_W-1:0] PC,
  output logic              Busy,
  output logic              Done
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              step_mode_q, step_mode_d;
  logic [INSN_W-1:0] out_word_q, out_word_d;
  logic              out_valid_q, out_valid_d;
  logic              loop_q;

  logic [ADDR_W:0]   len_clip;
  logic [INSN_W-1:0] rd_data;
  logic              ram_we;
  logic              issue;
  logic              last;

  assign len_clip = (Prog_Len > DEPTH_L) ? DEPTH_L : Prog_Len;
  assign last     = ({1'b0, pc_q} == (len_q - (ADDR_W+1)'(1)));
  assign ram_we   = Wr_En && ((state_q == IDLE) || (state_q == DONE));

  program_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i     (Clk),
    .we_i      (ram_we),
    .wr_addr_i (Wr_Addr),
    .wr_data_i (Wr_Data),
    .rd_addr_i (pc_q),
    .rd_data_o (rd_data)
  );

`ifdef SEQ_LOOP_EN
  logic loop_d;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      loop_q <= 1'b0;
    end else begin
      loop_q <= loop_d;
    end
  end

  always_comb begin
    loop_d = loop_q;
    if (!Halt && Start && ((state_q == IDLE) || (state_q == DONE))) begin
      loop_d = Loop;
    end
  end
`else
  assign loop_q = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    len_d       = len_q;
    step_mode_d = step_mode_q;
    out_word_d  = IDLE_WORD;
    out_valid_d = 1'b0;
    issue       = 1'b0;

    if (Halt) begin
      state_d = IDLE;
      pc_d    = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (Start) begin
            len_d       = len_clip;
            step_mode_d = Step_Mode;
            pc_d        = '0;
            if (len_clip == '0) begin
              state_d = DONE;
            end else begin
              state_d = Step_Mode ? STEP : RUN;
            end
          end
        end
        RUN, STEP: begin
          issue = !step_mode_q || Step;
        end
        default: begin
          state_d = IDLE;
          pc_d    = '0;
        end
      endcase
    end

    if (issue) begin
      out_word_d  = rd_data;
      out_valid_d = 1'b1;
      pc_d        = pc_q + (ADDR_W)'(1);
      // In loop mode the final word wraps back to address 0 and the program keeps going.
      if (last) begin
        if (loop_q) begin
          pc_d = '0;
        end else begin
          state_d = DONE;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      len_q       <= '0;
      step_mode_q <= 1'b0;
      out_word_q  <= IDLE_WORD;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      len_q       <= len_d;
      step_mode_q <= step_mode_d;
      out_word_q  <= out_word_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign Out_Word  = out_word_q;
  assign Out_Valid = out_valid_q;
  assign PC        = pc_q;
  assign Busy      = (state_q == RUN) || (state_q == STEP);
  assign Done      = (state_q == DONE);

endmodule

// File: tb/tb_tiny_program_sequencer.sv
// Directed plus randomized checks of tiny_program_sequencer against a shadow-RAM program model.
module tb_tiny_program_sequencer;

  localparam int          DEPTH  = 16;
  localparam int          ADDR_W = 4;
  localparam logic [11:0] IDLE_W = 12'hE00;

  logic              Clk       = 1'b0;
  logic              Rst_n     = 1'b0;
  logic              Wr_En     = 1'b0;
  logic [ADDR_W-1:0] Wr_Addr   = '0;
  logic [11:0]       Wr_Data   = '0;
  logic [ADDR_W:0]   Prog_Len  = '0;
  logic              Start     = 1'b0;
  logic              Step_Mode = 1'b0;
  logic              Step      = 1'b0;
  logic              Halt      = 1'b0;
`ifdef SEQ_LOOP_EN
  logic              Loop      = 1'b0;
`endif
  logic [11:0]       Out_Word;
  logic              Out_Valid;
  logic [ADDR_W-1:0] PC;
  logic              Busy;
  logic              Done;

  int n_chk  = 0;
  int n_fail = 0;

  logic [11:0] ref_mem [DEPTH];

  always #5 Clk = ~Clk;

  tiny_program_sequencer #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .IDLE_WORD (IDLE_W)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Wr_En     (Wr_En),
    .Wr_Addr   (Wr_Addr),
    .Wr_Data   (Wr_Data),
    .Prog_Len  (Prog_Len),
    .Start     (Start),
    .Step_Mode (Step_Mode),
    .Step      (Step),
    .Halt      (Halt),
`ifdef SEQ_LOOP_EN
    .Loop      (Loop),
`endif
    .Out_Word  (Out_Word),
    .Out_Valid (Out_Valid),
    .PC        (PC),
    .Busy      (Busy),
    .Done      (Done)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_valid"}, {31'd0, Out_Valid}, 32'd0);
    check({tag, "_word"},  {20'd0, Out_Word},  {20'd0, IDLE_W});
  endtask

  task automatic wr(input int a, input logic [11:0] d, input bit accept);
    Wr_En   = 1'b1;
    Wr_Addr = a[ADDR_W-1:0];
    Wr_Data = d;
    tick();
    Wr_En = 1'b0;
    if (accept) ref_mem[a] = d;
  endtask

  // Expected stream = the first min(len, DEPTH) words of the shadow RAM as it stood at Start.
  task automatic run_prog(input int len, input bit step, input int gap,
                          input int stray_at, input int wr_at, input bit wr_start);
    int          n;
    logic [11:0] nw;
    logic [11:0] exp_w [DEPTH];
    n = (len > DEPTH) ? DEPTH : len;
    if (wr_start) begin
      nw         = 12'($urandom);
      Wr_En      = 1'b1;
      Wr_Addr    = '0;
      Wr_Data    = nw;
      ref_mem[0] = nw;
    end
    exp_w     = ref_mem;
    Prog_Len  = len[ADDR_W:0];
    Step_Mode = step;
    Start     = 1'b1;
    tick();
    Start     = 1'b0;
    Wr_En     = 1'b0;
    Step_Mode = !step;
    check("start_valid", {31'd0, Out_Valid}, 32'd0);
    if (n == 0) begin
      check("len0_done", {31'd0, Done}, 32'd1);
      check("len0_busy", {31'd0, Busy}, 32'd0);
      repeat (2) begin
        tick();
        check_quiet("len0");
        check("len0_done_hold", {31'd0, Done}, 32'd1);
      end
      return;
    end
    check("start_busy", {31'd0, Busy}, 32'd1);
    for (int i = 0; i < n; i++) begin
      if (step) begin
        for (int g = 1; g < gap; g++) begin
          tick();
          check_quiet("step_gap");
        end
        Step = 1'b1;
      end else if (i == stray_at) begin
        Start = 1'b1;
      end
      if (i == wr_at) begin
        Wr_En   = 1'b1;
        Wr_Addr = 4'd2;
        Wr_Data = 12'hFFF;
      end
      tick();
      Start = 1'b0;
      Step  = 1'b0;
      Wr_En = 1'b0;
      check("issue_valid", {31'd0, Out_Valid}, 32'd1);
      check("issue_word", {20'd0, Out_Word}, {20'd0, exp_w[i]});
      if (i < n - 1) check("issue_busy", {31'd0, Busy}, 32'd1);
    end
    tick();
    check_quiet("end");
    check("end_done", {31'd0, Done}, 32'd1);
    check("end_busy", {31'd0, Busy}, 32'd0);
    check("end_pc", {28'd0, PC}, 32'(n % DEPTH));
    tick();
    check_quiet("end_hold");
  endtask

  initial begin
    #12;
    check("rst_word", {20'd0, Out_Word}, {20'd0, IDLE_W});
    check("rst_valid", {31'd0, Out_Valid}, 32'd0);
    check("rst_pc", {28'd0, PC}, 32'd0);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    tick();

    for (int a = 0; a < DEPTH; a++) begin
      case (a)
        0:       wr(a, 12'h105, 1'b1);
        1:       wr(a, 12'h203, 1'b1);
        2:       wr(a, 12'h300, 1'b1);
        default: wr(a, 12'($urandom), 1'b1);
      endcase
    end

    run_prog(3, 1'b0, 1, -1, -1, 1'b0);
    run_prog(3, 1'b1, 3, -1, -1, 1'b0);
    run_prog(0, 1'b0, 1, -1, -1, 1'b0);
    run_prog(20, 1'b0, 1, -1, -1, 1'b0);
    run_prog(16, 1'b1, 1, -1, -1, 1'b0);

    Prog_Len = 5'd8;
    Start    = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("halt_pre_word", {20'd0, Out_Word}, {20'd0, ref_mem[i]});
    end
    Halt = 1'b1;
    tick();
    Halt = 1'b0;
    check_quiet("halt");
    check("halt_pc", {28'd0, PC}, 32'd0);
    check("halt_busy", {31'd0, Busy}, 32'd0);
    check("halt_done", {31'd0, Done}, 32'd0);
    repeat (3) begin
      tick();
      check_quiet("halt_after");
    end

    Halt  = 1'b1;
    Start = 1'b1;
    tick();
    Halt  = 1'b0;
    Start = 1'b0;
    check("halt_start_busy", {31'd0, Busy}, 32'd0);
    check("halt_start_done", {31'd0, Done}, 32'd0);
    tick();
    check_quiet("halt_start");

    run_prog(6, 1'b0, 1, -1, 2, 1'b0);
    run_prog(4, 1'b0, 1, -1, -1, 1'b0);
    run_prog(8, 1'b0, 1, 3, -1, 1'b0);
    run_prog(3, 1'b0, 1, -1, -1, 1'b1);

    for (int r = 0; r < 10; r++) begin
      wr(int'($urandom_range(0, DEPTH - 1)), 12'($urandom), 1'b1);
      run_prog(int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)),
               int'($urandom_range(1, 3)), int'($urandom_range(0, 8)),
               int'($urandom_range(0, 8)), 1'($urandom_range(0, 1)));
    end

    Prog_Len = 5'd8;
    Start    = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tick();
    Rst_n = 1'b0;
    #2;
    check("amid_rst_word", {20'd0, Out_Word}, {20'd0, IDLE_W});
    check("amid_rst_valid", {31'd0, Out_Valid}, 32'd0);
    check("amid_rst_pc", {28'd0, PC}, 32'd0);
    check("amid_rst_busy", {31'd0, Busy}, 32'd0);
    check("amid_rst_done", {31'd0, Done}, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    tick();
    check_quiet("post_rst");
    run_prog(5, 1'b0, 1, -1, -1, 1'b0);

`ifdef SEQ_LOOP_EN
    wr(0, 12'h1AA, 1'b1);
    wr(1, 12'h2BB, 1'b1);
    Loop     = 1'b1;
    Prog_Len = 5'd2;
    Start    = 1'b1;
    tick();
    Start = 1'b0;
    Loop  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("loop_valid", {31'd0, Out_Valid}, 32'd1);
      check("loop_word", {20'd0, Out_Word}, (i % 2 == 0) ? 32'h1AA : 32'h2BB);
      check("loop_done", {31'd0, Done}, 32'd0);
    end
    Halt = 1'b1;
    tick();
    Halt = 1'b0;
    check_quiet("loop_halt");
    check("loop_halt_busy", {31'd0, Busy}, 32'd0);
    check("loop_halt_pc", {28'd0, PC}, 32'd0);
    Loop = 1'b1;
    run_prog(0, 1'b0, 1, -1, -1, 1'b0);
    Loop = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
